alu_shift_sequencer: RTL and testbench
======================================

ALU_SHIFT_SEQUENCER -- requirements
Module: alu_shift_sequencer

Interface
REQ-001 The block SHALL have parameter COUNT_BITS, default 5, giving the number of low count bits used (the x86 shift-count mask).
REQ-002 The block SHALL have ports clk, input, 1, clock; all state changes on the rising edge.
REQ-003 The block SHALL have ports reset_n, input, 1, reset; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request one sequenced operation; sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1, cancel the operation in progress.
REQ-006 The block SHALL have port op, input, MC_ALUOp_t_BITS, the ALU op to repeat (SHL/SHR/SAR/ROL/ROR/RCL/RCR).
REQ-007 The block SHALL have port is_8_bit, input, 1, operand width select.
REQ-008 The block SHALL have ports a_in (input, 16, operand), count (input, 8, raw count as from CL) and flags_in (input, 16, initial flags).
REQ-009 The block SHALL have ALU-side ports: alu_a (output, 16), alu_b (output, 16), alu_op (output, MC_ALUOp_t_BITS), alu_is_8_bit (output, 1), alu_flags_in (output, 16), alu_out (input, 16), alu_flags_out (input, 16).
REQ-010 The block SHALL have result ports: busy (output, 1), done (output, 1, one-cycle pulse), result (output, 16), flags_out (output, 16).

Function
REQ-011 States SHALL be IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch op, is_8_bit, a_in and flags_in into its working registers, and latch count[COUNT_BITS-1:0] into the iteration counter.
  - Masked count 0: next state DONE.
  - Masked count nonzero: next state RUN.
REQ-013 While in RUN, the ALU-side outputs SHALL be driven as follows.
  - alu_a = working value, alu_b = 16'd1, alu_flags_in = working flags.
  - alu_op and alu_is_8_bit = latched values.
REQ-014 On each RUN edge, the block SHALL:
  - capture alu_out into the working value and alu_flags_out into the working flags;
  - decrement the counter;
  - move to DONE when the counter was 1.
REQ-015 Latency: for masked count N, done SHALL be high in cycle N+1 after the start edge; N=0 gives done in cycle 1.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE.
REQ-017 result and flags_out SHALL hold the working value and working flags.
  - They are valid from the done cycle.
  - They are held until the next accepted start.
REQ-018 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-019 start SHALL be ignored while busy=1; no queuing.
REQ-020 abort in RUN or DONE SHALL force IDLE on the next edge with no done pulse; result and flags_out SHALL then retain the last partially captured values.
REQ-021 When abort=1 and start=1 in IDLE, abort SHALL win, and the start SHALL NOT be accepted.
REQ-022 In IDLE and DONE, the ALU-side outputs SHALL hold their last values, and alu_op SHALL equal ALUOp_SELA.
REQ-023 For 8-bit operations, the upper byte SHALL be carried through exactly as the ALU returns it; the block SHALL NOT perform any width masking.

Reset
REQ-024 On reset_n=0, the block SHALL asynchronously enter IDLE with all of the following cleared: busy=0, done=0, result=0, flags_out=0, counter=0 and working registers=0.
REQ-025 Reset asserted mid-RUN SHALL abandon the operation; the first start after reset_n rises SHALL behave as from power-up.

Structure
REQ-026 The ALUOp enumeration and MC_ALUOp_t_BITS SHALL come from the shared microcode package.
REQ-027 The state enumeration SHALL be local to the module.
REQ-028 The ALU SHALL be instantiated by the parent, not inside this block; no sub-module is required.

Verification
REQ-029 16-bit SHL, a_in=0x0001, count=3, flags_in=0 -> done in cycle 4 with result=0x0008 and CF=0.
REQ-030 count=0x20 (masked to 0), a_in=0x1234, flags_in=0x0001 -> done in cycle 1 with result=0x1234 and flags_out=0x0001.
REQ-031 8-bit ROR, a_in=0x0081, count=1 -> done in cycle 2 with result low byte 0xC0 and CF=1.
REQ-032 SHR, a_in=0x8000, count=4; abort in cycle 2 -> no done, IDLE next cycle, busy=0.
REQ-033 Second start while busy -> ignored, with exactly one done pulse.
REQ-034 reset_n low in cycle 2 of a count=5 op -> immediate IDLE, all outputs 0, no done.

Source files
------------

// File: rtl/alu_shift_sequencer_pkg.sv
// Shared microcode definitions: ALU operation encoding and the flag bit positions
// that the shift sequencer depends on.
package alu_shift_sequencer_pkg;

    localparam int MC_ALUOp_t_BITS = 5;
    localparam int CF_BIT          = 0;

    typedef enum logic [MC_ALUOp_t_BITS-1:0] {
        ALUOp_SELA = 5'd0,
        ALUOp_SELB = 5'd1,
        ALUOp_ADD  = 5'd2,
        ALUOp_ADC  = 5'd3,
        ALUOp_SUB  = 5'd4,
        ALUOp_SBB  = 5'd5,
        ALUOp_AND  = 5'd6,
        ALUOp_OR   = 5'd7,
        ALUOp_XOR  = 5'd8,
        ALUOp_SHL  = 5'd9,
        ALUOp_SHR  = 5'd10,
        ALUOp_SAR  = 5'd11,
        ALUOp_ROL  = 5'd12,
        ALUOp_ROR  = 5'd13,
        ALUOp_RCL  = 5'd14,
        ALUOp_RCR  = 5'd15
    } ALUOp_t;

endpackage

// File: rtl/alu_shift_sequencer.sv
// Repeats a single-bit shift/rotate on an external ALU once per masked count,
// capturing the ALU result and flags each cycle until the count is exhausted.
module alu_shift_sequencer
    import alu_shift_sequencer_pkg::*;
#(
    parameter int COUNT_BITS = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  ALUOp_t      op,
    input  logic        is_8_bit,
    input  logic [15:0] a_in,
    input  logic [7:0]  count,
    input  logic [15:0] flags_in,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output ALUOp_t      alu_op,
    output logic        alu_is_8_bit,
    output logic [15:0] alu_flags_in,
    input  logic [15:0] alu_out,
    input  logic [15:0] alu_flags_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [15:0] flags_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    ALUOp_t                op_r;
    logic                  is_8_bit_r;
    logic [15:0]           work_val;
    logic [15:0]           work_flags;
    logic [COUNT_BITS-1:0] cnt;
    logic [COUNT_BITS-1:0] masked_count;
    logic                  unused_count;

    assign masked_count = count[COUNT_BITS-1:0];
    assign unused_count = &{1'b0, count};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            op_r       <= ALUOp_SELA;
            is_8_bit_r <= 1'b0;
            work_val   <= '0;
            work_flags <= '0;
            alu_b      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        op_r       <= op;
                        is_8_bit_r <= is_8_bit;
                        work_val   <= a_in;
                        work_flags <= flags_in;
                        cnt        <= masked_count;
                        alu_b      <= 16'd1;
                        busy       <= 1'b1;
                        if (masked_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // An aborted edge captures nothing, leaving the prior partial result visible.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        work_val   <= alu_out;
                        work_flags <= alu_flags_out;
                        cnt        <= cnt - COUNT_BITS'(1);
                        if (cnt == COUNT_BITS'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a        = work_val;
    assign alu_flags_in = work_flags;
    assign alu_is_8_bit = is_8_bit_r;
    assign alu_op       = (state == RUN) ? op_r : ALUOp_SELA;
    assign result       = work_val;
    assign flags_out    = work_flags;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Bench for alu_shift_sequencer: a behavioural one-bit shift ALU closes the loop and a
// scoreboard of expected results/latencies is checked at each done pulse.
module tb_alu_shift_sequencer;
    import alu_shift_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort, is_8_bit;
    ALUOp_t      op;
    logic [15:0] a_in, flags_in;
    logic [7:0]  count;
    logic [15:0] alu_a, alu_b, alu_flags_in, alu_out, alu_flags_out;
    ALUOp_t      alu_op;
    logic        alu_is_8_bit;
    logic        busy, done;
    logic [15:0] result, flags_out;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    typedef struct {
        logic [15:0] res;
        logic [15:0] fl;
        int unsigned lat;
    } exp_t;
    exp_t sb[$];

    alu_shift_sequencer #(.COUNT_BITS(5)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .op(op),
        .is_8_bit(is_8_bit), .a_in(a_in), .count(count), .flags_in(flags_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_is_8_bit(alu_is_8_bit),
        .alu_flags_in(alu_flags_in), .alu_out(alu_out), .alu_flags_out(alu_flags_out),
        .busy(busy), .done(done), .result(result), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    // One-bit shift/rotate; returns {flags, value}. Upper byte passes through in 8-bit mode.
    function automatic logic [31:0] alu1(ALUOp_t o, logic w8, logic [15:0] a, logic [15:0] f);
        logic [15:0] r;
        logic c;
        r = a;
        c = f[0];
        if (w8) begin
            case (o)
                ALUOp_SHL: begin c = a[7]; r[7:0] = {a[6:0], 1'b0}; end
                ALUOp_SHR: begin c = a[0]; r[7:0] = {1'b0, a[7:1]}; end
                ALUOp_SAR: begin c = a[0]; r[7:0] = {a[7], a[7:1]}; end
                ALUOp_ROL: begin c = a[7]; r[7:0] = {a[6:0], a[7]}; end
                ALUOp_ROR: begin c = a[0]; r[7:0] = {a[0], a[7:1]}; end
                ALUOp_RCL: begin c = a[7]; r[7:0] = {a[6:0], f[0]}; end
                ALUOp_RCR: begin c = a[0]; r[7:0] = {f[0], a[7:1]}; end
                default: ;
            endcase
        end else begin
            case (o)
                ALUOp_SHL: begin c = a[15]; r = {a[14:0], 1'b0}; end
                ALUOp_SHR: begin c = a[0];  r = {1'b0, a[15:1]}; end
                ALUOp_SAR: begin c = a[0];  r = {a[15], a[15:1]}; end
                ALUOp_ROL: begin c = a[15]; r = {a[14:0], a[15]}; end
                ALUOp_ROR: begin c = a[0];  r = {a[0], a[15:1]}; end
                ALUOp_RCL: begin c = a[15]; r = {a[14:0], f[0]}; end
                ALUOp_RCR: begin c = a[0];  r = {f[0], a[15:1]}; end
                default: ;
            endcase
        end
        return {f[15:1], c, r};
    endfunction

    always_comb {alu_flags_out, alu_out} = alu1(alu_op, alu_is_8_bit, alu_a, alu_flags_in);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_expected(input ALUOp_t o, input logic w8, input logic [15:0] a,
                                 input logic [7:0] c, input logic [15:0] f);
        exp_t e;
        logic [31:0] vf;
        int unsigned n;
        n = c & 8'h1F;
        vf = {f, a};
        for (int unsigned i = 0; i < n; i++) vf = alu1(o, w8, vf[15:0], vf[31:16]);
        e.res = vf[15:0];
        e.fl  = vf[31:16];
        e.lat = n + 1;
        sb.push_back(e);
    endtask

    task automatic drive_start(input ALUOp_t o, input logic w8, input logic [15:0] a,
                               input logic [7:0] c, input logic [15:0] f);
        @(negedge clk);
        op = o; is_8_bit = w8; a_in = a; count = c; flags_in = f; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Full operation: push expectation, start, wait for done, compare against scoreboard head.
    task automatic do_op(input string tag, input ALUOp_t o, input logic w8, input logic [15:0] a,
                         input logic [7:0] c, input logic [15:0] f);
        exp_t e;
        int unsigned cyc;
        bit seen;
        push_expected(o, w8, a, c, f);
        drive_start(o, w8, a, c, f);
        seen = 0;
        cyc = 0;
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1;
            else check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
        end
        e = sb.pop_front();
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, cyc, e.lat);
        check({tag, "_result"}, {16'd0, result}, {16'd0, e.res});
        check({tag, "_flags"}, {16'd0, flags_out}, {16'd0, e.fl});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_result_held"}, {16'd0, result}, {16'd0, e.res});
    endtask

    initial begin
        int unsigned pulses;
        ALUOp_t ops[7];
        ops = '{ALUOp_SHL, ALUOp_SHR, ALUOp_SAR, ALUOp_ROL, ALUOp_ROR, ALUOp_RCL, ALUOp_RCR};
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = ALUOp_SELA; is_8_bit = 1'b0;
        a_in = '0; count = '0; flags_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_flags", {16'd0, flags_out}, 32'd0);
        check("rst_alu_op", {27'd0, alu_op}, {27'd0, ALUOp_SELA});
        reset_n = 1'b1;

        do_op("shl16", ALUOp_SHL, 1'b0, 16'h0001, 8'd3, 16'h0000);
        check("shl16_const", {16'd0, result}, 32'h0008);
        check("shl16_cf", {31'd0, flags_out[CF_BIT]}, 32'd0);

        do_op("cnt_mask", ALUOp_SHL, 1'b0, 16'h1234, 8'h20, 16'h0001);
        check("cnt_mask_const", {16'd0, result}, 32'h1234);
        check("cnt_mask_flags", {16'd0, flags_out}, 32'h0001);

        do_op("ror8", ALUOp_ROR, 1'b1, 16'h0081, 8'd1, 16'h0000);
        check("ror8_low", {24'd0, result[7:0]}, 32'hC0);
        check("ror8_cf", {31'd0, flags_out[CF_BIT]}, 32'd1);

        // Abort during cycle 2: one capture happened, none on the aborting edge.
        drive_start(ALUOp_SHR, 1'b0, 16'h8000, 8'd4, 16'h0000);
        @(negedge clk);
        check("abort_c1_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("abort_c2_done", {31'd0, done}, 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_partial", {16'd0, result}, 32'h4000);
        repeat (4) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end

        // abort beats start in IDLE
        abort = 1'b1; start = 1'b1; op = ALUOp_SHL; count = 8'd2; a_in = 16'h0F0F;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_wins_busy", {31'd0, busy}, 32'd0);
        check("abort_wins_result", {16'd0, result}, 32'h4000);

        // Second start while busy is dropped: one done, first operation's result.
        push_expected(ALUOp_ROL, 1'b0, 16'h8421, 8'd3, 16'h0000);
        drive_start(ALUOp_ROL, 1'b0, 16'h8421, 8'd3, 16'h0000);
        pulses = 0;
        for (int unsigned i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2 || i == 4) begin
                start = 1'b1; a_in = 16'hFFFF; count = 8'd1; op = ALUOp_SHR;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                exp_t e;
                pulses++;
                e = sb.pop_front();
                check("busy_start_lat", i, e.lat);
                check("busy_start_result", {16'd0, result}, {16'd0, e.res});
            end
        end
        start = 1'b0;
        check("busy_start_pulses", pulses, 32'd1);

        // Reset mid-run
        drive_start(ALUOp_SHL, 1'b0, 16'h0003, 8'd5, 16'h0001);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", {16'd0, result}, 32'd0);
        check("midrst_flags", {16'd0, flags_out}, 32'd0);
        check("midrst_alu_a", {16'd0, alu_a}, 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_no_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        do_op("post_rst", ALUOp_SHL, 1'b0, 16'h0003, 8'd5, 16'h0001);

        for (int unsigned k = 0; k < 8; k++) begin
            do_op("rand", ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                  16'($urandom), 8'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
